// File: rtl/adc_capture_sequencer_if.sv
// Signal bundle between the capture sequencer, the ADC pins and the per-channel RAM write port.
// slave is the sequencer side, master is whatever drives the control and ADC inputs.
interface adc_capture_sequencer_if #(
    parameter int NCH = 4,
    parameter int AW  = 9
);
    logic           start;
    logic           abort;
    logic [15:0]    period;
    logic [2:0]     chnl;
    logic           n_convst;
    logic           n_eoc;
    logic           n_cs;
    logic           n_rd;
    logic [7:0]     adc_in;
    logic [AW-1:0]  w_addr;
    logic [7:0]     w_data;
    logic [NCH-1:0] w_chsel;
    logic           wren;
    logic           busy;
    logic           done;
    logic           timeout_err;
    logic           overrun;

    modport master (
        output start, abort, period, n_eoc, adc_in,
        input  chnl, n_convst, n_cs, n_rd, w_addr, w_data, w_chsel, wren,
               busy, done, timeout_err, overrun
    );

    modport slave (
        input  start, abort, period, n_eoc, adc_in,
        output chnl, n_convst, n_cs, n_rd, w_addr, w_data, w_chsel, wren,
               busy, done, timeout_err, overrun
    );
endinterface

// File: rtl/adc_capture_sequencer.sv
// Armed multichannel ADC capture: scans NCH channels per frame at a programmable frame period
// and writes DEPTH frames into per-channel RAMs, with abort, EOC timeout and overrun reporting.
module adc_capture_sequencer #(
    parameter int NCH         = 4,
    parameter int DEPTH       = 512,
    parameter int AW          = 9,
    parameter int T_CONVST    = 2,
    parameter int T_RD        = 3,
    parameter int EOC_TIMEOUT = 255
) (
    input logic                    clk,
    input logic                    n_reset,
    adc_capture_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CONV, WAIT_EOC, READ, WRITE, NEXT, FWAIT, DONE} state_t;

    state_t         state_q;
    logic [1:0]     eoc_sync_q;
    logic [15:0]    cnt_q;
    logic [15:0]    timer_q;
    logic [15:0]    timer_d;
    logic [15:0]    period_q;
    logic [2:0]     ch_q;
    logic [2:0]     chnl_q;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  w_addr_q;
    logic [7:0]     w_data_q;
    logic [NCH-1:0] w_chsel_q;
    logic           n_convst_q, n_cs_q, n_rd_q, wren_q;
    logic           busy_q, done_q, timeout_err_q, overrun_q;

    logic eoc_s, last_ch, last_addr;
    logic accept_start, period_hit, launch, frame_start;

    assign eoc_s     = ~eoc_sync_q[1];
    assign last_ch   = (ch_q == 3'(NCH - 1));
    assign last_addr = (addr_q == AW'(DEPTH - 1));

    // The frame timer restarts on the first CONV cycle of every frame; period_hit means the
    // next frame may begin now (also true once the timer has run past the period: overrun).
    always_comb begin
        accept_start = ((state_q == IDLE) || (state_q == DONE)) && bus.start && !bus.abort;
        period_hit   = (period_q == 16'd0) || (timer_q >= period_q - 16'd1);
        launch       = !bus.abort && period_hit &&
                       (((state_q == NEXT) && last_ch && !last_addr) || (state_q == FWAIT));
        frame_start  = accept_start || launch;
        timer_d      = frame_start ? 16'd0 :
                       ((timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= IDLE;
            eoc_sync_q    <= 2'b11;
            cnt_q         <= '0;
            timer_q       <= '0;
            period_q      <= '0;
            ch_q          <= '0;
            chnl_q        <= '0;
            addr_q        <= '0;
            w_addr_q      <= '0;
            w_data_q      <= '0;
            w_chsel_q     <= '0;
            n_convst_q    <= 1'b1;
            n_cs_q        <= 1'b1;
            n_rd_q        <= 1'b1;
            wren_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            eoc_sync_q <= {eoc_sync_q[0], bus.n_eoc};
            timer_q    <= timer_d;
            if (frame_start) period_q <= bus.period;

            if (bus.abort && (state_q != IDLE)) begin
                state_q    <= IDLE;
                n_convst_q <= 1'b1;
                n_cs_q     <= 1'b1;
                n_rd_q     <= 1'b1;
                wren_q     <= 1'b0;
                w_chsel_q  <= '0;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
                ch_q       <= '0;
                addr_q     <= '0;
                cnt_q      <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (accept_start) begin
                            state_q       <= CONV;
                            ch_q          <= '0;
                            chnl_q        <= '0;
                            addr_q        <= '0;
                            cnt_q         <= '0;
                            n_convst_q    <= 1'b0;
                            busy_q        <= 1'b1;
                            done_q        <= 1'b0;
                            timeout_err_q <= 1'b0;
                            overrun_q     <= 1'b0;
                        end
                    end
                    CONV: begin
                        if (cnt_q == 16'(T_CONVST - 1)) begin
                            state_q    <= WAIT_EOC;
                            n_convst_q <= 1'b1;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    WAIT_EOC: begin
                        if (eoc_s) begin
                            state_q <= READ;
                            n_cs_q  <= 1'b0;
                            n_rd_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else if (cnt_q == 16'(EOC_TIMEOUT - 1)) begin
                            state_q       <= DONE;
                            timeout_err_q <= 1'b1;
                            busy_q        <= 1'b0;
                            done_q        <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    READ: begin
                        if (cnt_q == 16'(T_RD - 1)) begin
                            state_q   <= WRITE;
                            w_data_q  <= bus.adc_in;
                            n_cs_q    <= 1'b1;
                            n_rd_q    <= 1'b1;
                            wren_q    <= 1'b1;
                            w_chsel_q <= NCH'(1) << ch_q;
                            w_addr_q  <= addr_q;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    WRITE: begin
                        state_q   <= NEXT;
                        wren_q    <= 1'b0;
                        w_chsel_q <= '0;
                    end
                    NEXT: begin
                        cnt_q <= '0;
                        if (!last_ch) begin
                            state_q    <= CONV;
                            ch_q       <= ch_q + 3'd1;
                            chnl_q     <= ch_q + 3'd1;
                            n_convst_q <= 1'b0;
                        end else begin
                            ch_q <= '0;
                            if (last_addr) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                addr_q <= addr_q + AW'(1);
                                // No room left for a wait cycle: the frame ran into its period.
                                if (period_hit) begin
                                    if (period_q != 16'd0) overrun_q <= 1'b1;
                                    state_q    <= CONV;
                                    chnl_q     <= '0;
                                    n_convst_q <= 1'b0;
                                end else begin
                                    state_q <= FWAIT;
                                end
                            end
                        end
                    end
                    FWAIT: begin
                        if (period_hit) begin
                            state_q    <= CONV;
                            chnl_q     <= '0;
                            cnt_q      <= '0;
                            n_convst_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.chnl        = chnl_q;
    assign bus.n_convst    = n_convst_q;
    assign bus.n_cs        = n_cs_q;
    assign bus.n_rd        = n_rd_q;
    assign bus.w_addr      = w_addr_q;
    assign bus.w_data      = w_data_q;
    assign bus.w_chsel     = w_chsel_q;
    assign bus.wren        = wren_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.overrun     = overrun_q;
endmodule
